// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue/writeback pipeline.
// Instruction layout, ALU modes and the EX/WB stage bundles.
package alu_pkg;

  localparam int DW   = 8;
  localparam int NREG = 4;
  localparam int RW   = $clog2(NREG);
  localparam int IW   = 12;

  localparam int LDI_B    = 11;
  localparam int MODE_LSB = 8;
  localparam int RD_LSB   = 6;
  localparam int RA_LSB   = 4;
  localparam int RB_LSB   = 2;

  typedef enum logic [2:0] {
    M_ADD = 3'd0,
    M_SUB = 3'd1,
    M_INC = 3'd2,
    M_DEC = 3'd3,
    M_AND = 3'd4,
    M_OR  = 3'd5,
    M_XOR = 3'd6,
    M_NOT = 3'd7
  } mode_e;

  typedef struct packed {
    mode_e          mode;
    logic [RW-1:0]  rd;
    logic           ldi;
    logic [DW-1:0]  imm;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
  } ex_t;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [RW-1:0]  rd;
  } wb_t;

endpackage

// File: rtl/alu_regfile.sv
// Small register file: two async read ports, one debug port,
// one synchronous write port, cleared by async reset.
module alu_regfile
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [RW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [RW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [RW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b,
  input  logic [RW-1:0] dbg_raddr,
  output logic [DW-1:0] dbg_rdata
);

  logic [NREG-1:0][DW-1:0] rf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf <= '0;
    end else if (we) begin
      rf[waddr] <= wdata;
    end
  end

  assign rdata_a   = rf[raddr_a];
  assign rdata_b   = rf[raddr_b];
  assign dbg_rdata = rf[dbg_raddr];

endmodule

// File: rtl/alu_issue_unit.sv
// Two-stage issue/writeback front end for an external 8-bit ALU.
// EX drives the ALU; WB holds the result and writes the regfile.
module alu_issue_unit
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_instr,
  input  logic [DW-1:0] in_imm,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_mode,
  input  logic [DW-1:0] alu_out,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic [RW-1:0] res_rd,
  output logic          res_zero,
  input  logic [RW-1:0] dbg_raddr,
  output logic [DW-1:0] dbg_rdata
);

  ex_t           ex_q;
  wb_t           wb_q;
  logic          ex_valid;
  logic          wb_valid;
  logic          wb_adv;
  logic          ex_adv;
  logic          accept;
  logic [DW-1:0] ex_res;
  logic [DW-1:0] rf_a;
  logic [DW-1:0] rf_b;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [RW-1:0] ra;
  logic [RW-1:0] rb;
  logic          unused_rsvd;

  assign ra          = in_instr[RA_LSB +: RW];
  assign rb          = in_instr[RB_LSB +: RW];
  assign unused_rsvd = ^in_instr[1:0];

  assign wb_adv   = ~wb_valid | res_ready;
  assign ex_adv   = ex_valid & wb_adv;
  assign in_ready = ~ex_valid | ex_adv;
  assign accept   = in_valid & in_ready;
  assign ex_res   = ex_q.ldi ? ex_q.imm : alu_out;

  alu_regfile u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (ex_adv),
    .waddr     (ex_q.rd),
    .wdata     (ex_res),
    .raddr_a   (ra),
    .rdata_a   (rf_a),
    .raddr_b   (rb),
    .rdata_b   (rf_b),
    .dbg_raddr (dbg_raddr),
    .dbg_rdata (dbg_rdata)
  );

  // The retiring EX result is written on the same edge, so forward it.
  always_comb begin
    op_a = rf_a;
    op_b = rf_b;
    if (ex_adv && ex_q.rd == ra) op_a = ex_res;
    if (ex_adv && ex_q.rd == rb) op_b = ex_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q     <= '0;
      ex_valid <= 1'b0;
    end else if (accept) begin
      ex_q <= '{
        mode: mode_e'(in_instr[MODE_LSB +: 3]),
        rd:   in_instr[RD_LSB +: RW],
        ldi:  in_instr[LDI_B],
        imm:  in_imm,
        a:    op_a,
        b:    op_b
      };
      ex_valid <= 1'b1;
    end else if (ex_adv) begin
      ex_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q     <= '0;
      wb_valid <= 1'b0;
    end else if (ex_adv) begin
      wb_q     <= '{data: ex_res, rd: ex_q.rd};
      wb_valid <= 1'b1;
    end else if (res_ready) begin
      wb_valid <= 1'b0;
    end
  end

  assign alu_a     = ex_q.a;
  assign alu_b     = ex_q.b;
  assign alu_mode  = ex_q.mode;
  assign res_valid = wb_valid;
  assign res_data  = wb_q.data;
  assign res_rd    = wb_q.rd;
  assign res_zero  = (wb_q.data == '0);

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit with a behavioural ALU beside it and an
// in-order architectural model producing the expected result stream.
module tb_alu_issue_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_instr;
  logic [7:0]  in_imm;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_mode;
  logic [7:0]  alu_out;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_data;
  logic [1:0]  res_rd;
  logic        res_zero;
  logic [1:0]  dbg_raddr;
  logic [7:0]  dbg_rdata;

  int total = 0;
  int bad   = 0;

  logic [7:0] ref_rf [4];
  logic [9:0] exp_q [$];
  logic [7:0] got_q [$];

  alu_issue_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_imm    (in_imm),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_mode  (alu_mode),
    .alu_out   (alu_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_rd    (res_rd),
    .res_zero  (res_zero),
    .dbg_raddr (dbg_raddr),
    .dbg_rdata (dbg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] alu_ref(
    input logic [2:0] m, input logic [7:0] a, input logic [7:0] b);
    case (m)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a + 8'd1;
      3'd3:    return a - 8'd1;
      3'd4:    return a & b;
      3'd5:    return a | b;
      3'd6:    return a ^ b;
      default: return ~a;
    endcase
  endfunction

  always_comb alu_out = alu_ref(alu_mode, alu_a, alu_b);

  function automatic logic [11:0] mk(
    input logic l, input logic [2:0] m,
    input logic [1:0] d, input logic [1:0] a, input logic [1:0] b);
    logic [1:0] rs;
    rs = 2'($urandom);
    return {l, m, d, a, b, rs};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic model_accept(input logic [11:0] ins, input logic [7:0] im);
    logic [7:0] r;
    if (ins[11]) r = im;
    else r = alu_ref(ins[10:8], ref_rf[ins[5:4]], ref_rf[ins[3:2]]);
    ref_rf[ins[7:6]] = r;
    exp_q.push_back({ins[7:6], r});
  endtask

  // Drive at the falling edge, then judge what the next rising edge transfers.
  task automatic step(input logic v, input logic [11:0] ins,
                      input logic [7:0] im, input logic rr);
    logic [9:0] e;
    @(negedge clk);
    in_valid  = v;
    in_instr  = ins;
    in_imm    = im;
    res_ready = rr;
    #1;
    if (res_valid && res_ready) begin
      chk("res_pending", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("res_data", res_data, e[7:0]);
        chk("res_rd", res_rd, e[9:8]);
        chk("res_zero", res_zero, e[7:0] == 8'h00);
        got_q.push_back(res_data);
      end
    end
    if (in_valid && in_ready) model_accept(in_instr, in_imm);
  endtask

  task automatic drain();
    repeat (3) step(1'b0, 12'h000, 8'h00, 1'b1);
  endtask

  task automatic chk_rf(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_raddr = 2'(i);
      #1;
      chk(tag, dbg_rdata, ref_rf[i]);
    end
  endtask

  initial begin
    logic [7:0] sa, sb;
    logic       v;
    logic [11:0] ins;
    logic [7:0] im;
    int acc;
    int cyc;

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    in_imm = '0;
    res_ready = 1'b1;
    dbg_raddr = '0;
    for (int i = 0; i < 4; i++) ref_rf[i] = 8'h00;

    repeat (2) @(negedge clk);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_zero", res_zero, 1);
    chk("rst_res_data", res_data, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_mode", alu_mode, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // back-to-back with bypass
    got_q.delete();
    step(1, mk(1, 3'd0, 2'd0, 2'd0, 2'd0), 8'h05, 1);
    chk("t2_rdy0", in_ready, 1);
    step(1, mk(1, 3'd0, 2'd1, 2'd0, 2'd0), 8'h03, 1);
    chk("t2_rdy1", in_ready, 1);
    step(1, mk(0, 3'd0, 2'd2, 2'd0, 2'd1), 8'hAA, 1);
    chk("t2_rdy2", in_ready, 1);
    drain();
    chk("t2_cnt", got_q.size(), 3);
    chk("t2_r0", got_q[0], 8'h05);
    chk("t2_r1", got_q[1], 8'h03);
    chk("t2_add", got_q[2], 8'h08);
    dbg_raddr = 2'd2;
    #1;
    chk("t2_dbg_r2", dbg_rdata, 8'h08);

    // wrap-around
    got_q.delete();
    step(1, mk(1, 3'd0, 2'd0, 2'd0, 2'd0), 8'hFF, 1);
    step(1, mk(0, 3'd2, 2'd1, 2'd0, 2'd3), 8'h00, 1);
    step(1, mk(0, 3'd3, 2'd2, 2'd1, 2'd3), 8'h00, 1);
    drain();
    chk("t3_ff", got_q[0], 8'hFF);
    chk("t3_inc", got_q[1], 8'h00);
    chk("t3_dec", got_q[2], 8'hFF);

    // logic/sub modes into r3
    got_q.delete();
    step(1, mk(1, 3'd0, 2'd0, 2'd0, 2'd0), 8'hF0, 1);
    step(1, mk(1, 3'd0, 2'd1, 2'd0, 2'd0), 8'h3C, 1);
    for (int m = 1; m <= 7; m++) begin
      if (m == 2 || m == 3) continue;
      step(1, mk(0, 3'(m), 2'd3, 2'd0, 2'd1), 8'h77, 1);
    end
    drain();
    chk("t4_cnt", got_q.size(), 7);
    chk("t4_sub", got_q[2], 8'hB4);
    chk("t4_and", got_q[3], 8'h30);
    chk("t4_or", got_q[4], 8'hFC);
    chk("t4_xor", got_q[5], 8'hCC);
    chk("t4_not", got_q[6], 8'h0F);

    // backpressure
    step(1, mk(1, 3'd0, 2'd0, 2'd0, 2'd0), 8'h12, 1);
    step(1, mk(1, 3'd0, 2'd1, 2'd0, 2'd0), 8'h35, 1);
    drain();
    got_q.delete();
    step(1, mk(0, 3'd0, 2'd2, 2'd0, 2'd1), 8'h00, 0);
    step(1, mk(0, 3'd1, 2'd3, 2'd1, 2'd0), 8'h00, 0);
    ins = mk(0, 3'd6, 2'd0, 2'd0, 2'd1);
    step(1, ins, 8'h00, 0);
    chk("t5_stall_rdy", in_ready, 0);
    chk("t5_wb_full", res_valid, 1);
    chk("t5_alu_a", alu_a, 8'h35);
    sa = alu_a;
    sb = alu_b;
    step(1, ins, 8'h00, 1);
    chk("t5_hold_a", alu_a, sa);
    chk("t5_hold_b", alu_b, sb);
    chk("t5_release_rdy", in_ready, 1);
    drain();
    chk("t5_cnt", got_q.size(), 3);
    chk("t5_add", got_q[0], 8'h47);
    chk("t5_sub", got_q[1], 8'h23);
    chk("t5_xor", got_q[2], 8'h27);

    // randomized traffic
    acc = 0;
    cyc = 0;
    v = 1'b0;
    ins = '0;
    im = '0;
    while (acc < 1000 && cyc < 20000) begin
      if (!v && $urandom_range(0, 3) != 0) begin
        v = 1'b1;
        ins = 12'($urandom);
        im = 8'($urandom);
      end
      step(v, ins, im, $urandom_range(0, 3) != 0);
      if (v && in_ready) begin
        acc++;
        v = 1'b0;
      end
      cyc++;
    end
    chk("rand_accepted", acc, 1000);
    drain();
    chk("rand_drained", exp_q.size(), 0);
    chk_rf("rand_rf");

    // asynchronous reset with work in flight
    step(1, mk(1, 3'd0, 2'd1, 2'd0, 2'd0), 8'h55, 0);
    step(1, mk(1, 3'd0, 2'd2, 2'd0, 2'd0), 8'h66, 0);
    step(0, 12'h000, 8'h00, 0);
    chk("mid_wb_full", res_valid, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_res_valid", res_valid, 0);
    chk("mid_res_zero", res_zero, 1);
    for (int i = 0; i < 4; i++) ref_rf[i] = 8'h00;
    exp_q.delete();
    chk_rf("mid_rf");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_in_ready", in_ready, 1);
    got_q.delete();
    step(1, mk(0, 3'd2, 2'd3, 2'd1, 2'd0), 8'h00, 1);
    drain();
    chk("mid_inc_after", got_q[0], 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
